// File: rtl/l2_burst_reader_pkg.sv
// l2_burst_reader_pkg
// Shared constants and types for the L2 burst-read path between the L1
// instruction cache and the single-word memory bus.
//   L2_BURST_MAX   largest burst (words) the reader buffers
//   L2_WORD_BYTES  bytes per memory word (address stride)
//   L2_WORD_W      data width of one word in bits
//   l2br_state_e   burst reader FSM states
package l2_burst_reader_pkg;

    localparam int L2_BURST_MAX  = 16;
    localparam int L2_WORD_BYTES = 4;
    localparam int L2_WORD_W     = L2_WORD_BYTES * 8;

    typedef enum logic [1:0] {
        L2BR_IDLE   = 2'd0,
        L2BR_FETCH  = 2'd1,
        L2BR_STREAM = 2'd2
    } l2br_state_e;

endpackage

// File: rtl/l2_burst_reader_if.sv
// l2_burst_reader_if
// Bundles the L1-facing burst port and the memory-facing req/ack bus.
//   rreq/addr/burst_size   burst request from the L1 cache
//   rdata/busy             streamed words and fetch-in-progress flag
//   mem_req/mem_addr       single-word read request to memory
//   mem_rdata/mem_ack      memory read data and completion strobe
// Modport slave is the reader's view, master the environment's view.
interface l2_burst_reader_if
    import l2_burst_reader_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic                 rreq;
    logic [ADDR_W-1:0]    addr;
    logic [4:0]           burst_size;
    logic [L2_WORD_W-1:0] rdata;
    logic                 busy;
    logic                 mem_req;
    logic [ADDR_W-1:0]    mem_addr;
    logic [L2_WORD_W-1:0] mem_rdata;
    logic                 mem_ack;

    modport slave (
        input  rreq, addr, burst_size, mem_rdata, mem_ack,
        output rdata, busy, mem_req, mem_addr
    );

    modport master (
        output rreq, addr, burst_size, mem_rdata, mem_ack,
        input  rdata, busy, mem_req, mem_addr
    );

endinterface

// File: rtl/l2_burst_buffer.sv
// l2_burst_buffer
// DEPTH x word register file holding one fetched burst. Not reset: contents
// persist across bursts and resets by design.
//   clk    write clock
//   we     write enable
//   waddr  write index
//   wdata  write data
//   raddr  read index (asynchronous read)
//   rdata  word at raddr
module l2_burst_buffer
    import l2_burst_reader_pkg::*;
#(
    parameter int DEPTH = L2_BURST_MAX,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [L2_WORD_W-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [L2_WORD_W-1:0] rdata
);

    logic [L2_WORD_W-1:0] mem_r [DEPTH];

    // Single write port storage update.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/l2_burst_reader.sv
// l2_burst_reader
// Serves an L1 burst read: fetches up to MAX_BURST sequential words over a
// single-outstanding req/ack memory bus, buffers them, then streams them back
// one word per cycle starting the cycle busy falls.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    l2_burst_reader_if.slave (rreq/addr/burst_size/rdata/busy and
//          mem_req/mem_addr/mem_rdata/mem_ack)
module l2_burst_reader
    import l2_burst_reader_pkg::*;
#(
    parameter int MAX_BURST = L2_BURST_MAX,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    l2_burst_reader_if.slave  bus
);

    localparam int IDX_W = $clog2(MAX_BURST);
    // One extra bit so a count of exactly MAX_BURST is representable.
    localparam int CNT_W = IDX_W + 1;

    l2br_state_e          state_r, state_s;
    logic                 busy_r, busy_s;
    logic                 mem_req_r, mem_req_s;
    logic [ADDR_W-1:0]    mem_addr_r, mem_addr_s;
    logic [CNT_W-1:0]     wr_cnt_r, wr_cnt_s;
    logic [CNT_W-1:0]     n_r, n_s;
    logic [CNT_W-1:0]     rd_idx_r, rd_idx_s;
    logic [CNT_W-1:0]     n_clamp_s;
    logic                 buf_we_s;
    logic [L2_WORD_W-1:0] buf_rdata_s;
    logic                 addr_lo_unused_s;

    // Byte offset within the word is not meaningful for word reads.
    assign addr_lo_unused_s = ^bus.addr[1:0];

    // Requested length, with 0 and oversize requests mapped to a full buffer.
    always_comb begin
        n_clamp_s = CNT_W'(MAX_BURST);
        if ((bus.burst_size == 5'd0) || (32'(bus.burst_size) > MAX_BURST)) begin
            n_clamp_s = CNT_W'(MAX_BURST);
        end else begin
            n_clamp_s = CNT_W'(bus.burst_size);
        end
    end

    // Next-state and datapath update for the burst FSM.
    always_comb begin
        state_s    = state_r;
        busy_s     = busy_r;
        mem_req_s  = mem_req_r;
        mem_addr_s = mem_addr_r;
        wr_cnt_s   = wr_cnt_r;
        n_s        = n_r;
        rd_idx_s   = rd_idx_r;
        buf_we_s   = 1'b0;
        case (state_r)
            L2BR_IDLE: begin
                if (bus.rreq) begin
                    n_s        = n_clamp_s;
                    mem_addr_s = {bus.addr[ADDR_W-1:2], 2'b00};
                    mem_req_s  = 1'b1;
                    busy_s     = 1'b1;
                    wr_cnt_s   = CNT_W'(0);
                    state_s    = L2BR_FETCH;
                end else begin
                    state_s    = L2BR_IDLE;
                end
            end
            L2BR_FETCH: begin
                if (bus.mem_ack) begin
                    buf_we_s   = 1'b1;
                    wr_cnt_s   = wr_cnt_r + CNT_W'(1);
                    mem_addr_s = mem_addr_r + ADDR_W'(L2_WORD_BYTES);
                    // Ack for the final word hands over to the stream phase.
                    if (wr_cnt_r == (n_r - CNT_W'(1))) begin
                        mem_req_s = 1'b0;
                        busy_s    = 1'b0;
                        rd_idx_s  = CNT_W'(0);
                        state_s   = L2BR_STREAM;
                    end else begin
                        state_s   = L2BR_FETCH;
                    end
                end else begin
                    state_s = L2BR_FETCH;
                end
            end
            L2BR_STREAM: begin
                // rd_idx stops on the last word so rdata keeps buf[n-1].
                if (rd_idx_r == (n_r - CNT_W'(1))) begin
                    state_s  = L2BR_IDLE;
                end else begin
                    rd_idx_s = rd_idx_r + CNT_W'(1);
                end
            end
            default: begin
                state_s   = L2BR_IDLE;
                busy_s    = 1'b0;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and control registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= L2BR_IDLE;
            busy_r     <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= '0;
            wr_cnt_r   <= '0;
            n_r        <= '0;
            rd_idx_r   <= '0;
        end else begin
            state_r    <= state_s;
            busy_r     <= busy_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            wr_cnt_r   <= wr_cnt_s;
            n_r        <= n_s;
            rd_idx_r   <= rd_idx_s;
        end
    end

    l2_burst_buffer #(
        .DEPTH (MAX_BURST),
        .AW    (IDX_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (wr_cnt_r[IDX_W-1:0]),
        .wdata (bus.mem_rdata),
        .raddr (rd_idx_r[IDX_W-1:0]),
        .rdata (buf_rdata_s)
    );

    assign bus.rdata    = buf_rdata_s;
    assign bus.busy     = busy_r;
    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = mem_addr_r;

endmodule

// File: tb/tb_l2_burst_reader.sv
// tb_l2_burst_reader
// Scoreboard bench: the stimulus process computes each burst's expected
// addresses and words from a memory model and queues them; a memory responder
// checks requests and supplies data; a monitor compares the stream.
module tb_l2_burst_reader;

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    logic [31:0] addr_q[$];
    logic [31:0] exp_q[$];
    int          len_q[$];
    logic [31:0] epoch;
    int          wait_cycles;
    int          ack_cnt;

    l2_burst_reader_if #(.ADDR_W(32)) bus ();

    l2_burst_reader #(.MAX_BURST(16), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] e);
        return (a * 32'h9E37_79B1) ^ e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Memory responder: checks each request address, waits, then acks.
    initial begin : responder
        bit          new_word;
        int          waits_left;
        logic [31:0] cur_addr;
        new_word      = 1'b1;
        waits_left    = 0;
        cur_addr      = 32'h0;
        ack_cnt       = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                new_word = 1'b1;
            end else if (bus.mem_req === 1'b1) begin
                if (new_word) begin
                    if (addr_q.size() == 0) fail_now("mem_req_unexpected");
                    else check("mem_addr", bus.mem_addr, addr_q.pop_front());
                    cur_addr   = bus.mem_addr;
                    waits_left = wait_cycles;
                    new_word   = 1'b0;
                end else begin
                    check("mem_addr_stable", bus.mem_addr, cur_addr);
                end
                if (waits_left == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr, epoch);
                    ack_cnt++;
                    new_word = 1'b1;
                end else begin
                    waits_left--;
                end
            end
            @(posedge clk);
            #1;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
        end
    end

    // Stream monitor: on busy falling, expects n consecutive words then a hold.
    initial begin : monitor
        bit          prev_busy;
        int          n;
        logic [31:0] last;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && bus.busy === 1'b0) begin
                    if (len_q.size() == 0) begin
                        fail_now("stream_unexpected");
                    end else begin
                        n    = len_q.pop_front();
                        last = 32'h0;
                        for (int k = 0; k < n; k++) begin
                            if (k > 0) @(negedge clk);
                            if (exp_q.size() == 0) begin
                                fail_now("stream_no_expect");
                            end else begin
                                last = exp_q.pop_front();
                                check("stream_word", bus.rdata, last);
                            end
                        end
                        @(negedge clk);
                        check("hold_last", bus.rdata, last);
                    end
                end
                prev_busy = (bus.busy === 1'b1);
            end
        end
    end

    // One burst; called in the posedge+1 phase with the reader idle.
    task automatic do_burst(input logic [31:0] a, input logic [4:0] sz, input int w,
                            input bit inj_f, input bit inj_s, input int abort_after);
        int          n;
        int          cnt;
        int          ack_base;
        logic [31:0] base;
        n    = (sz == 5'd0 || sz > 5'd16) ? 16 : int'(sz);
        base = {a[31:2], 2'b00};
        epoch       = $urandom;
        wait_cycles = w;
        for (int k = 0; k < n; k++) begin
            addr_q.push_back(base + 32'(4 * k));
            exp_q.push_back(mem_word(base + 32'(4 * k), epoch));
        end
        len_q.push_back(n);
        ack_base = ack_cnt;
        check("idle_busy", 32'(bus.busy), 32'd0);
        bus.rreq = 1'b1; bus.addr = a; bus.burst_size = sz;
        @(posedge clk); #1;
        bus.rreq = 1'b0; bus.addr = $urandom; bus.burst_size = 5'($urandom);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 2000) begin
            cnt++;
            if (abort_after > 0 && (ack_cnt - ack_base) == abort_after) begin
                reset = 1'b1;
                #1;
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_mem_req", 32'(bus.mem_req), 32'd0);
                check("rst_mem_addr", bus.mem_addr, 32'd0);
                @(posedge clk); #1;
                @(posedge clk); #1;
                for (int k = 0; k < n; k++) void'(exp_q.pop_back());
                void'(len_q.pop_back());
                addr_q.delete();
                reset = 1'b0;
                check("rst_rdata_buf0", bus.rdata, mem_word(base, epoch));
                @(posedge clk); #1;
                return;
            end
            bus.rreq = (inj_f && cnt == 2);
            bus.addr = $urandom;
            bus.burst_size = 5'($urandom);
            @(posedge clk); #1;
            bus.rreq = 1'b0;
        end
        check("busy_cycles", 32'(cnt), 32'(n * (w + 1)));
        check("ack_count", 32'(ack_cnt - ack_base), 32'(n));
        check("addr_q_empty", 32'(addr_q.size()), 32'd0);
        for (int k = 0; k < n; k++) begin
            bus.rreq = inj_s && (k == 1 || k == n - 1);
            bus.addr = $urandom;
            @(posedge clk); #1;
            bus.rreq = 1'b0;
        end
        check("busy_after_stream", 32'(bus.busy), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset          = 1'b1;
        bus.rreq       = 1'b0;
        bus.addr       = 32'h0;
        bus.burst_size = 5'd0;
        epoch          = 32'h0;
        wait_cycles    = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_mem_req", 32'(bus.mem_req), 32'd0);
        check("reset_mem_addr", bus.mem_addr, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_burst(32'h0000_1234, 5'd8, 0, 1'b0, 1'b0, 0);
        do_burst(32'h0000_1234, 5'd8, 3, 1'b0, 1'b0, 0);
        do_burst(32'h0000_4000, 5'd0, 0, 1'b0, 1'b0, 0);
        do_burst(32'h0000_8000, 5'd20, 1, 1'b0, 1'b0, 0);
        do_burst(32'hFFFF_FFF8, 5'd4, 0, 1'b0, 1'b0, 0);
        do_burst(32'h0000_2000, 5'd8, 1, 1'b0, 1'b0, 3);
        do_burst(32'h0000_2000, 5'd8, 0, 1'b0, 1'b0, 0);
        do_burst(32'h0000_3003, 5'd6, 2, 1'b1, 1'b1, 0);
        do_burst(32'h0000_5000, 5'd5, 0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 20; i++) begin
            do_burst($urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)),
                     1'($urandom), 1'($urandom), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("end_len_q_empty", 32'(len_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
